// File: rtl/mem_bus_arbiter_if.sv
// Bundle of the cache-side, memory-side and routed-response signals around the
// unified memory bus arbiter. The slave modport is the arbiter's view.
interface mem_bus_arbiter_if #(
    parameter int XLEN = 32
);
    logic [1:0]      ic_command;
    logic [XLEN-1:0] ic_addr;
    logic [1:0]      dc_command;
    logic [XLEN-1:0] dc_addr;
    logic [63:0]     dc_data;
    logic [1:0]      dc_size;

    logic [1:0]      proc2mem_command;
    logic [XLEN-1:0] proc2mem_addr;
    logic [63:0]     proc2mem_data;
    logic [1:0]      proc2mem_size;

    logic [3:0]      mem2proc_response;
    logic [63:0]     mem2proc_data;
    logic [3:0]      mem2proc_tag;

    logic [3:0]      ic_response;
    logic [3:0]      dc_response;
    logic [3:0]      ic_tag;
    logic [3:0]      dc_tag;
    logic [63:0]     mem2cache_data;
    logic [3:0]      outstanding;

    modport slave (
        input  ic_command, ic_addr, dc_command, dc_addr, dc_data, dc_size,
        input  mem2proc_response, mem2proc_data, mem2proc_tag,
        output proc2mem_command, proc2mem_addr, proc2mem_data, proc2mem_size,
        output ic_response, dc_response, ic_tag, dc_tag, mem2cache_data, outstanding
    );

    modport master (
        output ic_command, ic_addr, dc_command, dc_addr, dc_data, dc_size,
        output mem2proc_response, mem2proc_data, mem2proc_tag,
        input  proc2mem_command, proc2mem_addr, proc2mem_data, proc2mem_size,
        input  ic_response, dc_response, ic_tag, dc_tag, mem2cache_data, outstanding
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares the unified memory bus between the icache fetch port and the dcache port,
// holding a rejected grant and steering tagged load data back to its owner.
module mem_bus_arbiter #(
    parameter int STARVE_LIMIT    = 4,
    parameter int MAX_OUTSTANDING = 15
) (
    input logic           clock,
    input logic           reset,
    mem_bus_arbiter_if.slave bus
);
    localparam logic [1:0] BUS_NONE  = 2'd0;
    localparam logic [1:0] BUS_LOAD  = 2'd1;
    localparam logic [1:0] MEM_DOUBLE = 2'd3;

    typedef enum logic [1:0] {IDLE, LOCK_IC, LOCK_DC} state_t;

    state_t      state;
    logic [2:0]  starve_cnt;
    logic [15:0] tag_valid;
    logic [15:0] tag_owner;
    logic [3:0]  out_cnt;

    logic       at_limit;
    logic       ic_elig;
    logic       dc_elig;
    logic       starved;
    logic       grant_ic;
    logic       grant_dc;
    logic       accepted;
    logic       load_accept;
    logic       ret_hit;
    logic [3:0] ret_tag;

    assign at_limit = (out_cnt == 4'(MAX_OUTSTANDING));
    assign ic_elig  = (bus.ic_command != BUS_NONE) && ((bus.ic_command != BUS_LOAD) || !at_limit);
    assign dc_elig  = (bus.dc_command != BUS_NONE) && ((bus.dc_command != BUS_LOAD) || !at_limit);
    assign starved  = (int'(starve_cnt) >= STARVE_LIMIT);

    // A locked requester keeps the bus even if the other side now has priority.
    always_comb begin
        grant_ic = 1'b0;
        grant_dc = 1'b0;
        if (!reset) begin
            case (state)
                IDLE: begin
                    if (starved && ic_elig)
                        grant_ic = 1'b1;
                    else if (dc_elig)
                        grant_dc = 1'b1;
                    else if (ic_elig)
                        grant_ic = 1'b1;
                end
                LOCK_IC: grant_ic = ic_elig;
                LOCK_DC: grant_dc = dc_elig;
                default: begin
                    grant_ic = 1'b0;
                    grant_dc = 1'b0;
                end
            endcase
        end
    end

    assign accepted    = (grant_ic || grant_dc) && (bus.mem2proc_response != 4'd0);
    assign load_accept = accepted && ((grant_ic && bus.ic_command == BUS_LOAD) ||
                                      (grant_dc && bus.dc_command == BUS_LOAD));
    assign ret_tag     = bus.mem2proc_tag;
    assign ret_hit     = !reset && (ret_tag != 4'd0) && tag_valid[ret_tag];

    always_comb begin
        bus.proc2mem_command = BUS_NONE;
        bus.proc2mem_addr    = '0;
        bus.proc2mem_data    = '0;
        bus.proc2mem_size    = 2'd0;
        bus.ic_response      = 4'd0;
        bus.dc_response      = 4'd0;
        if (grant_ic) begin
            bus.proc2mem_command = bus.ic_command;
            bus.proc2mem_addr    = bus.ic_addr;
            bus.proc2mem_size    = MEM_DOUBLE;
            bus.ic_response      = bus.mem2proc_response;
        end else if (grant_dc) begin
            bus.proc2mem_command = bus.dc_command;
            bus.proc2mem_addr    = bus.dc_addr;
            bus.proc2mem_data    = bus.dc_data;
            bus.proc2mem_size    = bus.dc_size;
            bus.dc_response      = bus.mem2proc_response;
        end
    end

    // Returns are routed by the owner recorded before any same-cycle rewrite.
    assign bus.ic_tag         = (ret_hit && !tag_owner[ret_tag]) ? ret_tag : 4'd0;
    assign bus.dc_tag         = (ret_hit &&  tag_owner[ret_tag]) ? ret_tag : 4'd0;
    assign bus.mem2cache_data = reset ? 64'd0 : bus.mem2proc_data;
    assign bus.outstanding    = out_cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            starve_cnt <= 3'd0;
            tag_valid  <= '0;
            tag_owner  <= '0;
            out_cnt    <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_ic && !accepted)
                        state <= LOCK_IC;
                    else if (grant_dc && !accepted)
                        state <= LOCK_DC;
                end
                LOCK_IC: begin
                    if (bus.ic_command == BUS_NONE || (grant_ic && accepted))
                        state <= IDLE;
                end
                LOCK_DC: begin
                    if (bus.dc_command == BUS_NONE || (grant_dc && accepted))
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (bus.ic_command == BUS_NONE || (grant_ic && accepted))
                starve_cnt <= 3'd0;
            else if (!grant_ic && starve_cnt != 3'd7)
                starve_cnt <= starve_cnt + 3'd1;

            // The later write wins when a load reuses the tag being returned.
            if (ret_hit)
                tag_valid[ret_tag] <= 1'b0;
            if (load_accept) begin
                tag_valid[bus.mem2proc_response] <= 1'b1;
                tag_owner[bus.mem2proc_response] <= grant_dc;
            end

            case ({load_accept, ret_hit})
                2'b10: if (out_cnt != 4'hF) out_cnt <= out_cnt + 4'd1;
                2'b01: if (out_cnt != 4'h0) out_cnt <= out_cnt - 4'd1;
                default: out_cnt <= out_cnt;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed, table-driven check of the memory bus arbiter: grant priority, starvation,
// locking, tag routing, the outstanding limit and reset behaviour.
module tb_mem_bus_arbiter;
    localparam logic [1:0] N = 2'd0;
    localparam logic [1:0] L = 2'd1;
    localparam logic [1:0] S = 2'd2;

    typedef struct {
        logic [1:0]  ic_cmd;
        logic [31:0] ic_addr;
        logic [1:0]  dc_cmd;
        logic [31:0] dc_addr;
        logic [63:0] dc_data;
        logic [1:0]  dc_size;
        logic [3:0]  resp;
        logic [3:0]  mtag;
        logic [63:0] mdata;
        logic [1:0]  p_cmd;
        logic [31:0] p_addr;
        logic [63:0] p_data;
        logic [1:0]  p_size;
        logic [3:0]  ic_resp;
        logic [3:0]  dc_resp;
        logic [3:0]  ic_tag;
        logic [3:0]  dc_tag;
        logic [3:0]  out;
    } vec_t;

    logic clock = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    vec_t vecs[20];

    always #5 clock = ~clock;

    mem_bus_arbiter_if #(.XLEN(32)) bus ();

    mem_bus_arbiter #(.STARVE_LIMIT(4), .MAX_OUTSTANDING(15)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    function automatic vec_t mk(
        logic [1:0] ic_cmd, logic [31:0] ic_addr, logic [1:0] dc_cmd, logic [31:0] dc_addr,
        logic [63:0] dc_data, logic [1:0] dc_size, logic [3:0] resp, logic [3:0] mtag,
        logic [63:0] mdata, logic [1:0] p_cmd, logic [31:0] p_addr, logic [63:0] p_data,
        logic [1:0] p_size, logic [3:0] ic_resp, logic [3:0] dc_resp, logic [3:0] ic_tag,
        logic [3:0] dc_tag, logic [3:0] out);
        vec_t v;
        v.ic_cmd = ic_cmd;   v.ic_addr = ic_addr; v.dc_cmd = dc_cmd;   v.dc_addr = dc_addr;
        v.dc_data = dc_data; v.dc_size = dc_size; v.resp = resp;       v.mtag = mtag;
        v.mdata = mdata;     v.p_cmd = p_cmd;     v.p_addr = p_addr;   v.p_data = p_data;
        v.p_size = p_size;   v.ic_resp = ic_resp; v.dc_resp = dc_resp; v.ic_tag = ic_tag;
        v.dc_tag = dc_tag;   v.out = out;
        return v;
    endfunction

    task automatic expectVal(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        bus.ic_command        = v.ic_cmd;
        bus.ic_addr           = v.ic_addr;
        bus.dc_command        = v.dc_cmd;
        bus.dc_addr           = v.dc_addr;
        bus.dc_data           = v.dc_data;
        bus.dc_size           = v.dc_size;
        bus.mem2proc_response = v.resp;
        bus.mem2proc_tag      = v.mtag;
        bus.mem2proc_data     = v.mdata;
    endtask

    task automatic checkOutput(input string tag, input vec_t v);
        expectVal({tag, ".proc2mem_command"}, 64'(bus.proc2mem_command), 64'(v.p_cmd));
        expectVal({tag, ".proc2mem_addr"},    64'(bus.proc2mem_addr),    64'(v.p_addr));
        expectVal({tag, ".proc2mem_data"},    bus.proc2mem_data,         v.p_data);
        expectVal({tag, ".proc2mem_size"},    64'(bus.proc2mem_size),    64'(v.p_size));
        expectVal({tag, ".ic_response"},      64'(bus.ic_response),      64'(v.ic_resp));
        expectVal({tag, ".dc_response"},      64'(bus.dc_response),      64'(v.dc_resp));
        expectVal({tag, ".ic_tag"},           64'(bus.ic_tag),           64'(v.ic_tag));
        expectVal({tag, ".dc_tag"},           64'(bus.dc_tag),           64'(v.dc_tag));
        expectVal({tag, ".outstanding"},      64'(bus.outstanding),      64'(v.out));
        expectVal({tag, ".mem2cache_data"},   bus.mem2cache_data,        v.mdata);
    endtask

    // One bus cycle: drive after the edge, sample on the falling edge, then clock it in.
    task automatic runVec(input string tag, input vec_t v);
        applyStimulus(v);
        @(negedge clock);
        checkOutput(tag, v);
        @(posedge clock);
        #1;
    endtask

    initial begin
        int tags[10];
        vec_t idle;

        idle = mk(N,0, N,0,0,0, 0,0,0, N,0,0,0, 0,0,0,0,0);

        // Single icache load and its return, then a repeated (now spurious) tag.
        vecs[0]  = mk(L,32'h100, N,0,0,0, 3,0,0,             L,32'h100,0,3,    3,0,0,0,0);
        vecs[1]  = mk(N,0, N,0,0,0, 0,0,0,                   N,0,0,0,          0,0,0,0,1);
        vecs[2]  = mk(N,0, N,0,0,0, 0,3,64'hDEAD,            N,0,0,0,          0,0,3,0,1);
        vecs[3]  = mk(N,0, N,0,0,0, 0,3,64'hBEEF,            N,0,0,0,          0,0,0,0,0);
        // Both load every cycle: dcache four times, then the starved icache.
        vecs[4]  = mk(L,32'h200, L,32'h300,64'h55,2, 1,0,0,  L,32'h300,64'h55,2, 0,1,0,0,0);
        vecs[5]  = mk(L,32'h200, L,32'h300,64'h55,2, 2,0,0,  L,32'h300,64'h55,2, 0,2,0,0,1);
        vecs[6]  = mk(L,32'h200, L,32'h300,64'h55,2, 4,0,0,  L,32'h300,64'h55,2, 0,4,0,0,2);
        vecs[7]  = mk(L,32'h200, L,32'h300,64'h55,2, 5,0,0,  L,32'h300,64'h55,2, 0,5,0,0,3);
        vecs[8]  = mk(L,32'h200, L,32'h300,64'h55,2, 6,0,0,  L,32'h200,0,3,     6,0,0,0,4);
        vecs[9]  = mk(L,32'h200, L,32'h300,64'h55,2, 7,0,0,  L,32'h300,64'h55,2, 0,7,0,0,5);
        // Rejected dcache store stays locked even once the icache is starved.
        vecs[10] = mk(L,32'h200, S,32'h400,64'hAA,3, 0,0,0,  S,32'h400,64'hAA,3, 0,0,0,0,6);
        vecs[11] = mk(L,32'h200, S,32'h400,64'hAA,3, 0,0,0,  S,32'h400,64'hAA,3, 0,0,0,0,6);
        vecs[12] = mk(L,32'h200, S,32'h400,64'hAA,3, 0,0,0,  S,32'h400,64'hAA,3, 0,0,0,0,6);
        vecs[13] = mk(L,32'h200, S,32'h400,64'hAA,3, 9,0,0,  S,32'h400,64'hAA,3, 0,9,0,0,6);
        vecs[14] = mk(L,32'h200, L,32'h300,64'h55,2, 8,0,0,  L,32'h200,0,3,     8,0,0,0,6);
        vecs[15] = mk(N,0, N,0,0,0, 0,9,64'h1234,            N,0,0,0,          0,0,0,0,7);
        // Return of icache tag 6 while the dcache is granted tag 6.
        vecs[16] = mk(N,0, L,32'h500,64'h77,3, 6,6,64'hCAFE, L,32'h500,64'h77,3, 0,6,6,0,7);
        vecs[17] = mk(N,0, N,0,0,0, 0,6,0,                   N,0,0,0,          0,0,0,6,7);
        vecs[18] = mk(N,0, N,0,0,0, 0,5,0,                   N,0,0,0,          0,0,0,5,6);
        vecs[19] = mk(N,0, N,0,0,0, 0,0,0,                   N,0,0,0,          0,0,0,0,5);

        reset = 1'b1;
        applyStimulus(mk(L,32'h100, N,0,0,0, 3,3,0, N,0,0,0, 0,0,0,0,0));
        @(posedge clock);
        #1;
        expectVal("reset.proc2mem_command", 64'(bus.proc2mem_command), 64'd0);
        expectVal("reset.ic_response",      64'(bus.ic_response),      64'd0);
        expectVal("reset.ic_tag",           64'(bus.ic_tag),           64'd0);
        expectVal("reset.outstanding",      64'(bus.outstanding),      64'd0);
        applyStimulus(idle);
        reset = 1'b0;
        @(posedge clock);
        #1;

        for (int i = 0; i < 20; i++)
            runVec($sformatf("vec%0d", i), vecs[i]);

        // Fill to the limit with icache loads; five entries are still live.
        tags = '{3, 5, 6, 9, 10, 11, 12, 13, 14, 15};
        for (int i = 0; i < 10; i++)
            runVec($sformatf("fill%0d", i),
                   mk(L,32'h700, N,0,0,0, 4'(tags[i]),0,0, L,32'h700,0,3, 4'(tags[i]),0,0,0, 4'(5 + i)));
        runVec("limit_loads", mk(L,32'h700, L,32'h300,64'h55,2, 3,0,0, N,0,0,0, 0,0,0,0,15));
        runVec("limit_store", mk(L,32'h700, S,32'h600,64'h99,3, 4,0,0, S,32'h600,64'h99,3, 0,4,0,0,15));
        runVec("limit_return", mk(N,0, N,0,0,0, 0,1,64'h42, N,0,0,0, 0,0,0,1,15));
        runVec("limit_reload", mk(L,32'h700, N,0,0,0, 1,0,0, L,32'h700,0,3, 1,0,0,0,14));
        runVec("limit_full",   mk(N,0, N,0,0,0, 0,0,0, N,0,0,0, 0,0,0,0,15));

        // Reset in the middle of a cycle with a load on the bus.
        applyStimulus(mk(L,32'h800, N,0,0,0, 2,2,64'h77, N,0,0,0, 0,0,0,0,0));
        #2;
        reset = 1'b1;
        #1;
        expectVal("midreset.proc2mem_command", 64'(bus.proc2mem_command), 64'd0);
        expectVal("midreset.proc2mem_addr",    64'(bus.proc2mem_addr),    64'd0);
        expectVal("midreset.ic_response",      64'(bus.ic_response),      64'd0);
        expectVal("midreset.ic_tag",           64'(bus.ic_tag),           64'd0);
        expectVal("midreset.outstanding",      64'(bus.outstanding),      64'd0);
        expectVal("midreset.mem2cache_data",   bus.mem2cache_data,        64'd0);
        @(posedge clock);
        #1;
        applyStimulus(idle);
        reset = 1'b0;
        @(posedge clock);
        #1;
        runVec("post_reset_tag",    mk(N,0, N,0,0,0, 0,2,0, N,0,0,0, 0,0,0,0,0));
        runVec("post_reset_load",   mk(L,32'h900, N,0,0,0, 2,0,0, L,32'h900,0,3, 2,0,0,0,0));
        runVec("post_reset_return", mk(N,0, N,0,0,0, 0,2,64'h11, N,0,0,0, 0,0,2,0,1));
        runVec("post_reset_empty",  mk(N,0, N,0,0,0, 0,0,0, N,0,0,0, 0,0,0,0,0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
